counter_prescaler: RTL and testbench
====================================

# counter_prescaler

Programmable tick generator sitting directly upstream of the loadable up-counter; its single-cycle `tick` output drives the counter's `enable` input. It divides the system clock by a run-time divisor and emits one `tick` every N cycles while running. The divisor is updated through a ready/load handshake and applied without glitching the period in flight.

## Interface
- Parameters:
- `WIDTH`, 8: divisor and phase width in bits.
- `DEFAULT_DIV`, 4: divisor loaded at reset.
- Ports:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - `ctrl`, input, `Util_Control_T`: the control bundle, carrying the clock in `Util_Control_Clock(ctrl)` (rising-edge) and the reset in `Util_Control_Reset(ctrl)` (active-low, asynchronous).
- `run`, input, 1: enable division; sampled each rising edge.
- `div_d`, input, `WIDTH`: new divisor value.
- `div_load`, input, 1: request to load `div_d`.
- `div_ready`, output, 1: a divisor load will be accepted this cycle.
- `tick`, output, 1: one-cycle strobe to the downstream counter's `enable`.
- `phase`, output, `WIDTH`: current position within the period, 0..N-1.
- `busy`, output, 1: state is not IDLE.
- `oneshot`, input, 1: present only with `COUNTER_PRESCALER_ONESHOT_EN`.

## Operation
- States:
  - IDLE: stopped, `phase` is 0.
  - RUN: `phase` counts.
  - HOLD: oneshot finished; exists only when the macro is defined.
- Effective divisor N = `div_cur`, with 0 treated as 1.
- Transitions:
  - IDLE -> RUN at an edge where `run` is 1; `phase` is 0 after that edge.
  - RUN: `phase` increments each edge. At the edge where `tick` is 1, `phase` wraps to 0.
  - RUN -> IDLE at any edge where `run` is 0; `phase` is cleared to 0. A partial period is discarded with no tick.
- `tick` = (state == RUN) && (`phase` == N-1). It is a Moore output: combinational from registers only.
- Handshake:
  - `div_ready` = !`pending`.
  - A transfer occurs at an edge where `div_load` && `div_ready`.
  - In IDLE, a transfer writes `div_cur` directly.
  - In RUN, a transfer writes `div_next` and sets `pending`. The pending value is committed to `div_cur` at the next wrap edge, or at the edge entering IDLE, and `pending` clears at that same edge.
  - `div_load` while `div_ready` is 0 is ignored; there is no queueing.
- Simultaneous wrap and transfer in RUN: the transfer goes to `div_next` and `pending` is set. It is applied at the following wrap, not the current one.
- Arithmetic: `phase` is `WIDTH` bits. N = 2^WIDTH-1 is the maximum period, with no overflow beyond N-1.

## Timing
- Reset values: state IDLE, `phase` 0, `div_cur` = `DEFAULT_DIV`, `pending` 0, `tick` 0, `div_ready` 1, `busy` 0.
- Reset asserted mid-operation clears everything immediately, asynchronously, including any pending divisor.
- Latency: with `run` sampled high at edge 0, the first `tick` is high in cycle N after edge 0, i.e. after edge N-1. Subsequent ticks follow every N cycles.
- N = 1: `tick` is high in every RUN cycle.
- `run` deasserted: `tick` is 0 in the cycle after the sampling edge.
- A divisor change during RUN never produces a period shorter than min(old N, new N).

## Configuration
- `COUNTER_PRESCALER_ONESHOT_EN` defined:
  - Adds the `oneshot` port and the HOLD state.
  - When `oneshot` is 1 at the IDLE->RUN edge, the first wrap edge goes to HOLD instead of continuing RUN.
  - HOLD has `tick` 0, `phase` 0 and `busy` 1.
  - HOLD -> IDLE when `run` is 0.
- `COUNTER_PRESCALER_ONESHOT_EN` undefined: the port and the HOLD state are absent, and the block free-runs while `run` is 1.

## Structure
- Package `counter_pkg`: state enum typedef (IDLE/RUN/HOLD) and the `DEFAULT_DIV` default constant.
- Sub-module `counter_prescaler_shadow`: owns `div_cur`, `div_next`, `pending`, `div_ready` and the commit strobe input.
- The top level holds the FSM, the phase counter and the `tick` decode.

## Test plan
- Reset with `run` = 1, then release with default N = 4 -> `tick` in cycles 4, 8, 12 after release; `phase` cycles 0,1,2,3.
- In IDLE, `div_d` = 1 with `div_load` = 1, then `run` = 1 -> `tick` high every cycle; `div_ready` stays 1.
- In RUN at `phase` 1 with N = 4, load `div_d` = 6 -> `div_ready` drops next cycle; the current period stays 4; the next period is 6; `div_ready` returns to 1 after the wrap.
- Deassert `run` at `phase` 2 with N = 5 -> no tick; `phase` 0, `busy` 0 next cycle. Reassert -> first tick 5 cycles later.
- Assert reset (low) mid-period with `pending` set -> all outputs at reset values immediately; the divisor reverts to 4.
- With `COUNTER_PRESCALER_ONESHOT_EN`: `oneshot` = 1, `run` = 1, N = 3 -> exactly one tick in cycle 3, then HOLD with `busy` 1. `run` = 0 -> IDLE.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter prescaler slice.
// The optional one-shot mode is enabled by defining COUNTER_PRESCALER_ONESHOT_EN.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_DIV_C = 4;

endpackage : counter_pkg

// File: rtl/counter_prescaler_shadow.sv
// Divisor shadow register: holds the active divisor and one staged update.
// A staged value becomes active only on the commit strobe from the FSM.
module counter_prescaler_shadow
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             active_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] div_d_i,
  input  logic             commit_i,
  output logic [WIDTH-1:0] div_cur_o,
  output logic             div_ready_o
);

  logic [WIDTH-1:0] divCur_q, divCur_d;
  logic [WIDTH-1:0] divNext_q, divNext_d;
  logic             pending_q, pending_d;

  // A transfer is only possible while nothing is staged, so commit and
  // transfer never compete for the same registers in one cycle.
  always_comb begin
    divCur_d  = divCur_q;
    divNext_d = divNext_q;
    pending_d = pending_q;
    if (commit_i && pending_q) begin
      divCur_d  = divNext_q;
      pending_d = 1'b0;
    end
    if (load_i && !pending_q) begin
      if (active_i) begin
        divNext_d = div_d_i;
        pending_d = 1'b1;
      end else begin
        divCur_d = div_d_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      divCur_q  <= WIDTH'(DEFAULT_DIV);
      divNext_q <= WIDTH'(DEFAULT_DIV);
      pending_q <= 1'b0;
    end else begin
      divCur_q  <= divCur_d;
      divNext_q <= divNext_d;
      pending_q <= pending_d;
    end
  end

  assign div_cur_o   = divCur_q;
  assign div_ready_o = !pending_q;

endmodule : counter_prescaler_shadow

// File: rtl/counter_prescaler.sv
// Programmable tick generator feeding the up-counter enable.
// Define COUNTER_PRESCALER_ONESHOT_EN to add the oneshot input and HOLD state.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_C
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [WIDTH-1:0] div_d_i,
  input  logic             div_load_i,
`ifdef COUNTER_PRESCALER_ONESHOT_EN
  input  logic             oneshot_i,
`endif
  output logic             div_ready_o,
  output logic             tick_o,
  output logic [WIDTH-1:0] phase_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] divCur;
  logic [WIDTH-1:0] lastPhase;
  logic             commitStrobe;
  logic             tick;

`ifdef COUNTER_PRESCALER_ONESHOT_EN
  logic             oneshot_q, oneshot_d;
`endif

  counter_prescaler_shadow #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_shadow (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .active_i    (state_q != IDLE),
    .load_i      (div_load_i),
    .div_d_i     (div_d_i),
    .commit_i    (commitStrobe),
    .div_cur_o   (divCur),
    .div_ready_o (div_ready_o)
  );

  // A zero divisor behaves like one, so the last phase is 0 in both cases.
  assign lastPhase = (divCur == '0) ? '0 : divCur - WIDTH'(1);
  assign tick      = (state_q == RUN) && (phase_q == lastPhase);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    commitStrobe = 1'b0;
`ifdef COUNTER_PRESCALER_ONESHOT_EN
    oneshot_d    = oneshot_q;
`endif
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (run_i) begin
          state_d = RUN;
`ifdef COUNTER_PRESCALER_ONESHOT_EN
          oneshot_d = oneshot_i;
`endif
        end
      end
      RUN: begin
        if (!run_i) begin
          state_d      = IDLE;
          phase_d      = '0;
          commitStrobe = 1'b1;
        end else if (tick) begin
          phase_d      = '0;
          commitStrobe = 1'b1;
`ifdef COUNTER_PRESCALER_ONESHOT_EN
          if (oneshot_q) state_d = HOLD;
`endif
        end else begin
          phase_d = phase_q + WIDTH'(1);
        end
      end
`ifdef COUNTER_PRESCALER_ONESHOT_EN
      HOLD: begin
        phase_d = '0;
        if (!run_i) begin
          state_d      = IDLE;
          commitStrobe = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

`ifdef COUNTER_PRESCALER_ONESHOT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oneshot_q <= 1'b0;
    end else begin
      oneshot_q <= oneshot_d;
    end
  end
`endif

  assign tick_o  = tick;
  assign phase_o = phase_q;
  assign busy_o  = (state_q != IDLE);

endmodule : counter_prescaler

// File: tb/tb_counter_prescaler.sv
// Scoreboard bench for counter_prescaler; covers the one-shot mode when
// COUNTER_PRESCALER_ONESHOT_EN is defined.
module tb_counter_prescaler;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic             tick;
    logic [WIDTH-1:0] phase;
    logic             busy;
    logic             ready;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic             divLoad = 1'b0;
  logic [WIDTH-1:0] divD = '0;
`ifdef COUNTER_PRESCALER_ONESHOT_EN
  logic             oneshot = 1'b0;
`endif
  logic             divReady;
  logic             tick;
  logic [WIDTH-1:0] phase;
  logic             busy;

  obs_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  counter_prescaler #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .run_i       (run),
    .div_d_i     (divD),
    .div_load_i  (divLoad),
`ifdef COUNTER_PRESCALER_ONESHOT_EN
    .oneshot_i   (oneshot),
`endif
    .div_ready_o (divReady),
    .tick_o      (tick),
    .phase_o     (phase),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  // Drives inputs just after a rising edge and queues the outputs expected
  // for the rest of that cycle.
  task automatic applyStimulus(input logic rstn, input logic r, input logic ld,
                               input logic [WIDTH-1:0] d, input logic eTick,
                               input logic [WIDTH-1:0] ePhase, input logic eBusy,
                               input logic eReady);
    obs_t e;
    @(posedge clk);
    #1;
    rst_n   = rstn;
    run     = r;
    divLoad = ld;
    divD    = d;
    e.tick  = eTick;
    e.phase = ePhase;
    e.busy  = eBusy;
    e.ready = eReady;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input obs_t e);
    obs_t a;
    a.tick  = tick;
    a.phase = phase;
    a.busy  = busy;
    a.ready = divReady;
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL cycle check %0d at %0t: got tick=%0b phase=%0d busy=%0b ready=%0b, expected tick=%0b phase=%0d busy=%0b ready=%0b",
               checks, $time, a.tick, a.phase, a.busy, a.ready, e.tick, e.phase, e.busy, e.ready);
    end
  endtask

  // Monitor: compares the oldest queued expectation at every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    int guard;
    $display("[TB] start");

    // Held in reset with run high, then released; default N = 4.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 1, 0, 0, (i % 4) == 3, WIDTH'(i % 4), 1, 1);

    // Stop, load N = 1 while idle, run: tick every cycle.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 1, 1, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 0, 0, 1, 0, 1, 1);

    // Back to N = 4, load 6 at phase 1; a load of 9 while busy is dropped.
    applyStimulus(1, 0, 0, 0, 1, 0, 1, 1);
    applyStimulus(1, 0, 1, 4, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 1, 1, 6, 0, 1, 1, 1);
    applyStimulus(1, 1, 1, 9, 0, 2, 1, 0);
    applyStimulus(1, 1, 0, 0, 1, 3, 1, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 1, 0, 0, i == 5, WIDTH'(i), 1, 1);

    // N = 5, abort at phase 2 with no tick, then restart a full period.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 1, 5, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 2, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 1, 0, 0, i == 4, WIDTH'(i), 1, 1);

    // Stage 7, then reset mid-period: everything reverts, divisor back to 4.
    applyStimulus(1, 1, 1, 7, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 0, 0, i == 3, WIDTH'(i), 1, 1);

`ifdef COUNTER_PRESCALER_ONESHOT_EN
    // One-shot with N = 3: single tick, HOLD while run stays high.
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 1, 3, 0, 0, 0, 1);
    oneshot = 1'b1;
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 1, 1, 1);
    applyStimulus(1, 1, 0, 0, 1, 2, 1, 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    oneshot = 1'b0;
`endif

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_counter_prescaler
